// File: rtl/biriscv_fetch_fifo.sv
// Instruction buffer between fetch and decode: holds DEPTH 64-bit fetch responses
// and presents up to two in-order instructions per cycle from the registered head.
module biriscv_fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] pc_in_i,
  input  logic [63:0] data_in_i,
  input  logic        fault_in_i,
  output logic        accept_o,
  output logic        valid0_o,
  output logic [31:0] pc0_o,
  output logic [31:0] instr0_o,
  output logic        fault0_o,
  output logic        valid1_o,
  output logic [31:0] pc1_o,
  output logic [31:0] instr1_o,
  output logic        fault1_o,
  input  logic        pop0_i,
  input  logic        pop1_i
);

  logic [31:3]       r_pc    [DEPTH];
  logic [63:0]       r_data  [DEPTH];
  logic              r_fault [DEPTH];
  logic [DEPTH-1:0]  r_v0;
  logic [DEPTH-1:0]  r_v1;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_head_v0;
  logic w_head_v1;
  logic w_pop0;
  logic w_pop_both;
  logic w_retire;
  logic w_unused_pc;

  assign w_unused_pc = ^pc_in_i[1:0];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));
  assign accept_o   = ~w_full;
  assign w_push     = push_i & ~w_full & ~flush_i;
  assign w_head_v0  = r_v0[r_rd_ptr];
  assign w_head_v1  = r_v1[r_rd_ptr];
  assign w_pop0     = pop0_i & valid0_o;
  assign w_pop_both = pop0_i & pop1_i & valid1_o;
  // Head retires once its last remaining valid slot is consumed.
  assign w_retire   = w_pop_both | (w_pop0 & ~(w_head_v0 & w_head_v1));

  always_comb begin
    valid0_o = 1'b0;
    pc0_o    = '0;
    instr0_o = '0;
    fault0_o = 1'b0;
    valid1_o = 1'b0;
    pc1_o    = '0;
    instr1_o = '0;
    fault1_o = 1'b0;
    if (!w_empty) begin
      if (w_head_v0) begin
        valid0_o = 1'b1;
        pc0_o    = {r_pc[r_rd_ptr], 3'b000};
        instr0_o = r_data[r_rd_ptr][31:0];
        fault0_o = r_fault[r_rd_ptr];
        valid1_o = w_head_v1;
        if (w_head_v1) begin
          pc1_o    = {r_pc[r_rd_ptr], 3'b100};
          instr1_o = r_data[r_rd_ptr][63:32];
          fault1_o = r_fault[r_rd_ptr];
        end
      end else if (w_head_v1) begin
        valid0_o = 1'b1;
        pc0_o    = {r_pc[r_rd_ptr], 3'b100};
        instr0_o = r_data[r_rd_ptr][63:32];
        fault0_o = r_fault[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_v0     <= '0;
      r_v1     <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_v0     <= '0;
      r_v1     <= '0;
    end else begin
      if (w_push) begin
        r_v0[r_wr_ptr] <= ~pc_in_i[2];
        r_v1[r_wr_ptr] <= 1'b1;
        r_wr_ptr       <= r_wr_ptr + 1'b1;
      end
      if (w_pop_both) begin
        r_v0[r_rd_ptr] <= 1'b0;
        r_v1[r_rd_ptr] <= 1'b0;
      end else if (w_pop0) begin
        if (w_head_v0) r_v0[r_rd_ptr] <= 1'b0;
        else           r_v1[r_rd_ptr] <= 1'b0;
      end
      if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed behind a set slot-valid bit.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= pc_in_i[31:3];
      r_data[r_wr_ptr]  <= fault_in_i ? 64'd0 : data_in_i;
      r_fault[r_wr_ptr] <= fault_in_i;
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_fifo.sv
// Self-checking bench for biriscv_fetch_fifo: scoreboard of expected slots per accepted push.
module tb_biriscv_fetch_fifo;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, push_i, fault_in_i, pop0_i, pop1_i;
  logic [31:0] pc_in_i;
  logic [63:0] data_in_i;
  logic        accept_o, valid0_o, fault0_o, valid1_o, fault1_o;
  logic [31:0] pc0_o, instr0_o, pc1_o, instr1_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        f;
  } exp_t;

  exp_t sb[$];
  int   ent_slots[$];
  int   mcount = 0;

  always #5 clk_i = ~clk_i;

  biriscv_fetch_fifo #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i),
    .pc_in_i(pc_in_i), .data_in_i(data_in_i), .fault_in_i(fault_in_i),
    .accept_o(accept_o), .valid0_o(valid0_o), .pc0_o(pc0_o), .instr0_o(instr0_o),
    .fault0_o(fault0_o), .valid1_o(valid1_o), .pc1_o(pc1_o), .instr1_o(instr1_o),
    .fault1_o(fault1_o), .pop0_i(pop0_i), .pop1_i(pop1_i)
  );

  task automatic model_clear();
    sb.delete();
    ent_slots.delete();
    mcount = 0;
  endtask

  // Drives one clock of stimulus and updates the reference model.
  task automatic cycle(input logic ps, input logic [31:0] pc, input logic [63:0] d,
                       input logic f, input logic p0, input logic p1, input logic fl);
    logic acc;
    int   k;
    acc = (mcount != DEPTH);
    push_i = ps; pc_in_i = pc; data_in_i = d; fault_in_i = f;
    pop0_i = p0; pop1_i = p1; flush_i = fl;
    if (fl) begin
      model_clear();
    end else begin
      if (p0 && ent_slots.size() > 0) begin
        k = (p1 && ent_slots[0] == 2) ? 2 : 1;
        for (int j = 0; j < k; j++) void'(sb.pop_front());
        ent_slots[0] = ent_slots[0] - k;
        if (ent_slots[0] == 0) begin
          void'(ent_slots.pop_front());
          mcount--;
        end
      end
      if (ps && acc) begin
        if (!pc[2]) sb.push_back('{pc: {pc[31:3], 3'b000}, instr: f ? 32'd0 : d[31:0], f: f});
        sb.push_back('{pc: {pc[31:3], 3'b100}, instr: f ? 32'd0 : d[63:32], f: f});
        ent_slots.push_back(pc[2] ? 1 : 2);
        mcount++;
      end
    end
    @(posedge clk_i); #1;
    push_i = 1'b0; pop0_i = 1'b0; pop1_i = 1'b0; flush_i = 1'b0; fault_in_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    flush_i = 0; push_i = 0; pop0_i = 0; pop1_i = 0; fault_in_i = 0;
    pc_in_i = '0; data_in_i = '0;
    #2;
    checks++; if (valid0_o !== 1'b0) begin failures++; $display("FAIL por_valid0 got=%b exp=0", valid0_o); end
    checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL por_accept got=%b exp=1", accept_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    cycle(1, 32'h8000_0040, 64'h1111_1111_2222_2222, 0, 0, 0, 0);
    cycle(1, 32'h8000_0048, 64'h3333_3333_4444_4444, 0, 0, 0, 0);
    checks++; if (valid0_o !== 1'b1) begin failures++; $display("FAIL pre_rst_valid0 got=%b exp=1", valid0_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (valid0_o !== 1'b0) begin failures++; $display("FAIL rst_valid0 got=%b exp=0", valid0_o); end
    checks++; if (valid1_o !== 1'b0) begin failures++; $display("FAIL rst_valid1 got=%b exp=0", valid1_o); end
    checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL rst_accept got=%b exp=1", accept_o); end
    checks++; if (pc0_o !== 32'd0) begin failures++; $display("FAIL rst_pc0 got=%h exp=0", pc0_o); end
    checks++; if (instr0_o !== 32'd0) begin failures++; $display("FAIL rst_instr0 got=%h exp=0", instr0_o); end
    model_clear();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_aligned();
    cycle(1, 32'h8000_0000, 64'h0020_0113_0010_0093, 0, 0, 0, 0);
    checks++; if (valid0_o !== 1'b1) begin failures++; $display("FAIL al_valid0 got=%b exp=1", valid0_o); end
    checks++; if (pc0_o !== 32'h8000_0000) begin failures++; $display("FAIL al_pc0 got=%h exp=80000000", pc0_o); end
    checks++; if (instr0_o !== 32'h0010_0093) begin failures++; $display("FAIL al_instr0 got=%h exp=00100093", instr0_o); end
    checks++; if (valid1_o !== 1'b1) begin failures++; $display("FAIL al_valid1 got=%b exp=1", valid1_o); end
    checks++; if (pc1_o !== 32'h8000_0004) begin failures++; $display("FAIL al_pc1 got=%h exp=80000004", pc1_o); end
    checks++; if (instr1_o !== 32'h0020_0113) begin failures++; $display("FAIL al_instr1 got=%h exp=00200113", instr1_o); end
    cycle(0, 0, 0, 0, 1, 1, 0);
    checks++; if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin failures++; $display("FAIL al_empty got=%b%b exp=00", valid0_o, valid1_o); end
  endtask

  task automatic test_partial();
    cycle(1, 32'h8000_0004, 64'hAAAA_0001_BBBB_0002, 0, 0, 0, 0);
    checks++; if (valid0_o !== 1'b1) begin failures++; $display("FAIL odd_valid0 got=%b exp=1", valid0_o); end
    checks++; if (pc0_o !== 32'h8000_0004) begin failures++; $display("FAIL odd_pc0 got=%h exp=80000004", pc0_o); end
    checks++; if (instr0_o !== 32'hAAAA_0001) begin failures++; $display("FAIL odd_instr0 got=%h exp=aaaa0001", instr0_o); end
    checks++; if (valid1_o !== 1'b0) begin failures++; $display("FAIL odd_valid1 got=%b exp=0", valid1_o); end
    cycle(0, 0, 0, 0, 1, 0, 0);
    checks++; if (valid0_o !== 1'b0) begin failures++; $display("FAIL odd_retire got=%b exp=0", valid0_o); end
    cycle(1, 32'h8000_0010, 64'h0000_0022_0000_0011, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    checks++; if (pc0_o !== sb[0].pc) begin failures++; $display("FAIL part_pc0 got=%h exp=%h", pc0_o, sb[0].pc); end
    checks++; if (instr0_o !== sb[0].instr) begin failures++; $display("FAIL part_instr0 got=%h exp=%h", instr0_o, sb[0].instr); end
    checks++; if (valid1_o !== 1'b0) begin failures++; $display("FAIL part_valid1 got=%b exp=0", valid1_o); end
    cycle(0, 0, 0, 0, 1, 0, 0);
    checks++; if (valid0_o !== 1'b0) begin failures++; $display("FAIL part_retire got=%b exp=0", valid0_o); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) begin
      checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL fill_accept%0d got=%b exp=1", i, accept_o); end
      cycle(1, 32'h8000_0100 + 32'(8 * i), {32'(2 * i + 1), 32'(2 * i)}, 0, 0, 0, 0);
    end
    checks++; if (accept_o !== 1'b0) begin failures++; $display("FAIL full_accept got=%b exp=0", accept_o); end
    cycle(1, 32'h8000_0F00, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 0);
    checks++; if (accept_o !== 1'b0) begin failures++; $display("FAIL drop_accept got=%b exp=0", accept_o); end
    checks++; if (pc0_o !== sb[0].pc) begin failures++; $display("FAIL full_head got=%h exp=%h", pc0_o, sb[0].pc); end
    cycle(0, 0, 0, 0, 1, 1, 0);
    checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL unfull_accept got=%b exp=1", accept_o); end
    for (int i = 4; i < 10; i++) begin
      if (sb.size() >= 2) begin
        checks++; if (pc0_o !== sb[0].pc || instr0_o !== sb[0].instr) begin failures++; $display("FAIL wrap_out0 got=%h/%h exp=%h/%h", pc0_o, instr0_o, sb[0].pc, sb[0].instr); end
        checks++; if (pc1_o !== sb[1].pc || instr1_o !== sb[1].instr) begin failures++; $display("FAIL wrap_out1 got=%h/%h exp=%h/%h", pc1_o, instr1_o, sb[1].pc, sb[1].instr); end
      end
      cycle(1, 32'h8000_0100 + 32'(8 * i), {32'(2 * i + 1), 32'(2 * i)}, 0, 1, 1, 0);
    end
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      checks++; if (valid0_o !== 1'b1 || pc0_o !== sb[0].pc || instr0_o !== sb[0].instr) begin failures++; $display("FAIL drain_out0 got=%b/%h/%h exp=1/%h/%h", valid0_o, pc0_o, instr0_o, sb[0].pc, sb[0].instr); end
      cycle(0, 0, 0, 0, 1, 1, 0);
    end
    checks++; if (sb.size() != 0 || valid0_o !== 1'b0) begin failures++; $display("FAIL drain_end got=%0d/%b exp=0/0", sb.size(), valid0_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h8000_0200 + 32'(8 * i), {32'(i + 100), 32'(i + 200)}, 0, 0, 0, 0);
    cycle(1, 32'h8000_0300, 64'h5555_5555_6666_6666, 0, 1, 0, 1);
    checks++; if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b%b exp=00", valid0_o, valid1_o); end
    checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL fl_accept got=%b exp=1", accept_o); end
    cycle(1, 32'h8000_2000, 64'h7777_7777_8888_8888, 0, 0, 0, 0);
    checks++; if (pc0_o !== 32'h8000_2000) begin failures++; $display("FAIL fl_newhead got=%h exp=80002000", pc0_o); end
    cycle(0, 0, 0, 0, 1, 1, 0);
    checks++; if (valid0_o !== 1'b0) begin failures++; $display("FAIL fl_onlyone got=%b exp=0", valid0_o); end
    model_clear();
  endtask

  task automatic test_fault();
    cycle(1, 32'h8000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
    checks++; if (valid0_o !== 1'b1 || valid1_o !== 1'b1) begin failures++; $display("FAIL ft_valid got=%b%b exp=11", valid0_o, valid1_o); end
    checks++; if (fault0_o !== 1'b1 || fault1_o !== 1'b1) begin failures++; $display("FAIL ft_fault got=%b%b exp=11", fault0_o, fault1_o); end
    checks++; if (instr0_o !== 32'd0 || instr1_o !== 32'd0) begin failures++; $display("FAIL ft_instr got=%h/%h exp=0/0", instr0_o, instr1_o); end
    checks++; if (instr0_o !== sb[0].instr || fault0_o !== sb[0].f) begin failures++; $display("FAIL ft_sb got=%h/%b exp=%h/%b", instr0_o, fault0_o, sb[0].instr, sb[0].f); end
    cycle(0, 0, 0, 0, 1, 1, 0);
    checks++; if (fault0_o !== 1'b0 || valid0_o !== 1'b0) begin failures++; $display("FAIL ft_clear got=%b/%b exp=0/0", fault0_o, valid0_o); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_partial();
    test_full_wrap();
    test_flush();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
